// File: rtl/alu_issue.sv
// Decode/issue stage: turns RV32I OP, OP-IMM and LUI instructions into ALU
// operands and a function code, held in a one-entry ID/EX register.
module alu_issue #(
  parameter int unsigned N  = 32,
  parameter int unsigned FW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [N-1:0]  rs1_data,
  input  logic [N-1:0]  rs2_data,
  input  logic          flush,
  input  logic          ex_ready,
  output logic          ex_valid,
  output logic [N-1:0]  ex_x,
  output logic [N-1:0]  ex_y,
  output logic [FW-1:0] ex_funct,
  output logic [4:0]    ex_rd,
  output logic          ex_wen,
  output logic          illegal
);

  localparam logic [FW-1:0] FnAnd = FW'(0);
  localparam logic [FW-1:0] FnOr  = FW'(1);
  localparam logic [FW-1:0] FnXor = FW'(2);
  localparam logic [FW-1:0] FnSlt = FW'(4);
  localparam logic [FW-1:0] FnSll = FW'(5);
  localparam logic [FW-1:0] FnSrl = FW'(6);
  localparam logic [FW-1:0] FnAdd = FW'(7);
  localparam logic [FW-1:0] FnSub = FW'(8);
  localparam logic [FW-1:0] FnSra = FW'(9);

  localparam logic [6:0] OpReg = 7'b0110011;
  localparam logic [6:0] OpImm = 7'b0010011;
  localparam logic [6:0] OpLui = 7'b0110111;

  logic [6:0]    w_opcode;
  logic [2:0]    w_funct3;
  logic          w_f7_zero;
  logic          w_f7_alt;
  logic [N-1:0]  w_imm;
  logic [N-1:0]  w_shamt_imm;
  logic [N-1:0]  w_shamt_reg;
  logic [N-1:0]  w_x;
  logic [N-1:0]  w_y;
  logic [FW-1:0] w_funct;
  logic          w_ill;
  logic          w_accept;

  logic          r_valid;
  logic [N-1:0]  r_x;
  logic [N-1:0]  r_y;
  logic [FW-1:0] r_funct;
  logic [4:0]    r_rd;
  logic          r_wen;
  logic          r_illegal;

  assign w_opcode    = instr[6:0];
  assign w_funct3    = instr[14:12];
  assign w_f7_zero   = (instr[31:25] == 7'b0000000);
  assign w_f7_alt    = (instr[31:25] == 7'b0100000);
  assign w_imm       = {{(N-12){instr[31]}}, instr[31:20]};
  // The ALU shifts by the full y, so the shift amount must be masked to 5 bits.
  assign w_shamt_imm = {{(N-5){1'b0}}, instr[24:20]};
  assign w_shamt_reg = {{(N-5){1'b0}}, rs2_data[4:0]};

  always_comb begin
    w_x     = rs1_data;
    w_y     = rs2_data;
    w_funct = FnAdd;
    w_ill   = 1'b0;
    case (w_opcode)
      OpReg: begin
        case (w_funct3)
          3'b000: begin
            w_funct = w_f7_alt ? FnSub : FnAdd;
            w_ill   = !(w_f7_zero || w_f7_alt);
          end
          3'b001: begin
            w_funct = FnSll;
            w_y     = w_shamt_reg;
            w_ill   = !w_f7_zero;
          end
          3'b010: begin
            w_funct = FnSlt;
            w_ill   = !w_f7_zero;
          end
          3'b100: begin
            w_funct = FnXor;
            w_ill   = !w_f7_zero;
          end
          3'b101: begin
            w_funct = w_f7_alt ? FnSra : FnSrl;
            w_y     = w_shamt_reg;
            w_ill   = !(w_f7_zero || w_f7_alt);
          end
          3'b110: begin
            w_funct = FnOr;
            w_ill   = !w_f7_zero;
          end
          3'b111: begin
            w_funct = FnAnd;
            w_ill   = !w_f7_zero;
          end
          default: w_ill = 1'b1;
        endcase
      end
      OpImm: begin
        w_y = w_imm;
        case (w_funct3)
          3'b000: w_funct = FnAdd;
          3'b001: begin
            w_funct = FnSll;
            w_y     = w_shamt_imm;
            w_ill   = !w_f7_zero;
          end
          3'b010: w_funct = FnSlt;
          3'b100: w_funct = FnXor;
          3'b101: begin
            w_funct = w_f7_alt ? FnSra : FnSrl;
            w_y     = w_shamt_imm;
            w_ill   = !(w_f7_zero || w_f7_alt);
          end
          3'b110: w_funct = FnOr;
          3'b111: w_funct = FnAnd;
          default: w_ill = 1'b1;
        endcase
      end
      OpLui: begin
        w_x     = '0;
        w_y     = {instr[31:12], 12'b0};
        w_funct = FnAdd;
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign in_ready = !flush && (!r_valid || ex_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_funct   <= '0;
      r_rd      <= '0;
      r_wen     <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept && w_ill;
      if (w_accept && !w_ill) begin
        r_valid <= 1'b1;
        r_x     <= w_x;
        r_y     <= w_y;
        r_funct <= w_funct;
        r_rd    <= instr[11:7];
        r_wen   <= (instr[11:7] != 5'd0);
      end else if (ex_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ex_valid = r_valid;
  assign ex_x     = r_x;
  assign ex_y     = r_y;
  assign ex_funct = r_funct;
  assign ex_rd    = r_rd;
  assign ex_wen   = r_wen;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, illegal pulse, backpressure,
// flush and asynchronous reset.
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_x;
  logic [31:0] ex_y;
  logic [3:0]  ex_funct;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic        illegal;

  int n_total = 0;
  int n_pass  = 0;

  alu_issue #(.N(32), .FW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .flush    (flush),
    .ex_ready (ex_ready),
    .ex_valid (ex_valid),
    .ex_x     (ex_x),
    .ex_y     (ex_y),
    .ex_funct (ex_funct),
    .ex_rd    (ex_rd),
    .ex_wen   (ex_wen),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    instr    = i;
    rs1_data = a;
    rs2_data = b;
  endtask

  task automatic chk_entry(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [3:0] f, input logic [4:0] rd, input logic wen);
    chk({tag, ".valid"}, {31'b0, ex_valid}, 32'd1);
    chk({tag, ".x"}, ex_x, x);
    chk({tag, ".y"}, ex_y, y);
    chk({tag, ".funct"}, {28'b0, ex_funct}, {28'b0, f});
    chk({tag, ".rd"}, {27'b0, ex_rd}, {27'b0, rd});
    chk({tag, ".wen"}, {31'b0, ex_wen}, {31'b0, wen});
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    instr    = 32'h0;
    rs1_data = 32'h0;
    rs2_data = 32'h0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    tick();
    chk("rst.valid", {31'b0, ex_valid}, 32'd0);
    chk("rst.illegal", {31'b0, illegal}, 32'd0);
    chk("rst.x", ex_x, 32'd0);
    chk("rst.y", ex_y, 32'd0);
    chk("rst.funct", {28'b0, ex_funct}, 32'd0);
    chk("rst.rd", {27'b0, ex_rd}, 32'd0);
    chk("rst.wen", {31'b0, ex_wen}, 32'd0);
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;

    drive(32'h002081B3, 32'd5, 32'd7);
    tick();
    chk_entry("add", 32'd5, 32'd7, 4'd7, 5'd3, 1'b1);

    drive(32'h402081B3, 32'd5, 32'd7);
    tick();
    chk_entry("sub", 32'd5, 32'd7, 4'd8, 5'd3, 1'b1);

    drive(32'hFFF00093, 32'd0, 32'h1234);
    tick();
    chk_entry("addi", 32'd0, 32'hFFFFFFFF, 4'd7, 5'd1, 1'b1);

    drive(32'h40435293, 32'h80000000, 32'h55);
    tick();
    chk_entry("srai", 32'h80000000, 32'd4, 4'd9, 5'd5, 1'b1);

    drive(32'h002091B3, 32'd1, 32'h25);
    tick();
    chk_entry("sll", 32'd1, 32'd5, 4'd5, 5'd3, 1'b1);

    drive(32'h0020C1B3, 32'hF0F0, 32'h0FF0);
    tick();
    chk_entry("xor", 32'hF0F0, 32'h0FF0, 4'd2, 5'd3, 1'b1);

    drive(32'h12345137, 32'hDEADBEEF, 32'h1);
    tick();
    chk_entry("lui", 32'd0, 32'h12345000, 4'd7, 5'd2, 1'b1);

    // SLTU is undecodable; the held LUI pops because ex_ready is high.
    drive(32'h0020B1B3, 32'd1, 32'd2);
    tick();
    chk("sltu.illegal", {31'b0, illegal}, 32'd1);
    chk("sltu.valid", {31'b0, ex_valid}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("sltu.illegal_drop", {31'b0, illegal}, 32'd0);
    chk("sltu.valid_after", {31'b0, ex_valid}, 32'd0);

    drive(32'h022081B3, 32'd1, 32'd2);
    tick();
    chk("badf7.illegal", {31'b0, illegal}, 32'd1);
    chk("badf7.valid", {31'b0, ex_valid}, 32'd0);

    drive(32'h00208033, 32'd3, 32'd4);
    tick();
    chk_entry("rd0", 32'd3, 32'd4, 4'd7, 5'd0, 1'b0);
    chk("rd0.illegal", {31'b0, illegal}, 32'd0);

    in_valid = 1'b0;
    tick();
    chk("pop.valid", {31'b0, ex_valid}, 32'd0);

    // Backpressure: ADD held for three cycles while ADDI waits.
    ex_ready = 1'b0;
    drive(32'h002081B3, 32'd5, 32'd7);
    tick();
    chk_entry("bp.add", 32'd5, 32'd7, 4'd7, 5'd3, 1'b1);
    drive(32'hFFF00093, 32'd0, 32'd9);
    #1;
    chk("bp.in_ready", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp.hold_ready", {31'b0, in_ready}, 32'd0);
      chk_entry("bp.hold", 32'd5, 32'd7, 4'd7, 5'd3, 1'b1);
    end
    ex_ready = 1'b1;
    #1;
    chk("bp.ready_up", {31'b0, in_ready}, 32'd1);
    tick();
    chk_entry("bp.addi", 32'd0, 32'hFFFFFFFF, 4'd7, 5'd1, 1'b1);

    // Flush while holding, with an instruction offered that must not be taken.
    ex_ready = 1'b0;
    drive(32'h402081B3, 32'd8, 32'd2);
    flush = 1'b1;
    #1;
    chk("flush.in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("flush.valid", {31'b0, ex_valid}, 32'd0);
    chk("flush.illegal", {31'b0, illegal}, 32'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("flush.after", {31'b0, ex_valid}, 32'd0);

    // Asynchronous reset in the middle of a hold.
    drive(32'h002081B3, 32'd5, 32'd7);
    tick();
    in_valid = 1'b0;
    chk_entry("mid.add", 32'd5, 32'd7, 4'd7, 5'd3, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid.valid", {31'b0, ex_valid}, 32'd0);
    chk("mid.x", ex_x, 32'd0);
    chk("mid.y", ex_y, 32'd0);
    chk("mid.funct", {28'b0, ex_funct}, 32'd0);
    chk("mid.rd", {27'b0, ex_rd}, 32'd0);
    chk("mid.wen", {31'b0, ex_wen}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst.valid", {31'b0, ex_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
